dht22_responder: RTL
====================

// Module: dht22_responder
// PURPOSE
//  Synthesizable DHT22 sensor model: the sensor end of the single-wire bus whose host end is DHT22.
//  Detects the host start pulse and returns a 40-bit frame with DHT22 timing:
//  humidity[15:0], temperature[15:0], checksum[7:0].
//  Serves as the loopback target for board-level simulation and FPGA self-test of the DHT22 reader.
// PARAMETERS
//  CLKS_PER_US    50   clk cycles per microsecond; all timings below are in us times this value
//  MIN_START_US   800  minimum host low time accepted as a start request
//  RESP_DELAY_US  30   gap between host release and the sensor ack
//  ACK_US         80   duration of ack low and of ack high
//  BIT_LOW_US     50   low slot that precedes every bit, and the end-of-frame low
//  BIT0_HIGH_US   26   high time that encodes a 0
//  BIT1_HIGH_US   70   high time that encodes a 1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  dht_in       in   1   sampled bus level (async; pad input)
//  dht_oe       out  1   1 = drive bus low (open-drain enable); 0 = release (pull-up)
//  humidity     in   16  value to report; sampled on start acceptance
//  temperature  in   16  value to report; sampled on start acceptance
//  err_inject   in   1   when 1 at start acceptance, the checksum sent is inverted
//  busy         out  1   1 from start acceptance until the frame ends
//  frame_done   out  1   one-cycle pulse on the cycle the end-of-frame low is released
// BEHAVIOUR
//  Reset (asynchronous, while reset=0)
//  - dht_oe=0, busy=0, frame_done=0, state=IDLE, counters=0.
//  - Bus is released immediately, including in the middle of a frame; no partial frame resumes.
//  Input path
//  - dht_in passes through a 2-flop synchronizer (2-cycle latency).
//  - All decisions use the synchronized level.
//  - Its reset value is 1 (idle bus).
//  Timing
//  - One duration counter; in each timed state it counts N*CLKS_PER_US cycles, then changes state.
//  - The counter width covers MIN_START_US*CLKS_PER_US; it saturates and never wraps.
//  States
//  - IDLE: dht_oe=0. Synced line falls 1->0 -> START_LOW, counter cleared.
//    A line that is already low when reset releases is ignored until it has been seen high.
//  - START_LOW: count while low. On rising edge:
//    - count >= MIN_START_US*CLKS_PER_US -> accept: latch humidity, temperature, err_inject; busy=1; -> RESP_DELAY.
//    - otherwise (glitch) -> IDLE with no response.
//  - RESP_DELAY: dht_oe=0 for RESP_DELAY_US -> ACK_LOW.
//  - ACK_LOW: dht_oe=1 for ACK_US -> ACK_HIGH.
//  - ACK_HIGH: dht_oe=0 for ACK_US -> BIT_LOW.
//  - BIT_LOW: dht_oe=1 for BIT_LOW_US -> BIT_HIGH.
//  - BIT_HIGH: dht_oe=0 for BIT1_HIGH_US if the current bit=1, else BIT0_HIGH_US.
//    - Then the bit index increments; index<40 -> BIT_LOW, index==40 -> END_LOW.
//  - END_LOW: dht_oe=1 for BIT_LOW_US, then dht_oe=0, frame_done=1 for one cycle, busy=0 -> IDLE.
//  Frame content (MSB first)
//  - Frame = {humidity, temperature, cks}.
//  - cks = (hum[15:8]+hum[7:0]+temp[15:8]+temp[7:0]) mod 256, 8-bit wraparound.
//  - cks is inverted when err_inject was latched as 1.
//  - Frame values are frozen at acceptance; input changes during busy do not affect the frame in flight.
//  Bus and collisions
//  - The responder never reads the bus after acceptance; host activity during busy is ignored.
//  - A new start is only detected after returning to IDLE.
//  - dht_oe is registered, so there is no combinational path from dht_in.
// TESTING (sim with CLKS_PER_US=2)
//  - hum=16'h028C, temp=16'h015F, host low 1000us then release:
//    - ack low 80us, then 40 bits decode to 028C_015F_EE.
//    - frame_done pulses once; busy falls on the same cycle.
//  - Host low 500us then release -> no dht_oe activity, busy stays 0, state returns to IDLE.
//  - hum=16'hFFFF, temp=16'hFFFF -> cks=8'hFC (wraparound).
//  - Same values with err_inject=1 -> cks=8'h03.
//  - Change hum to 16'h0000 mid-frame -> the frame in flight still carries 028C; the next frame carries 0000.
//  - Assert reset=0 during bit 20 of a frame:
//    - dht_oe=0 and busy=0 immediately.
//    - A subsequent valid start produces a full, correct 40-bit frame.
//  - Bit timing: 0-bit high=52 clk and 1-bit high=140 clk (+/-1 clk).
//    Every low slot=100 clk. Response begins 60 clk after the synced release.

Source files
------------

// File: rtl/dht22_responder.sv
// DHT22 sensor-side model: waits for a host start pulse on the single-wire
// bus, then answers with the ack and a 40-bit {humidity, temperature, checksum}
// frame using DHT22 slot timing. dht_oe=1 pulls the open-drain bus low.
module dht22_responder #(
  parameter int unsigned CLKS_PER_US   = 50,
  parameter int unsigned MIN_START_US  = 800,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ACK_US        = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dht_in,
  output logic        dht_oe,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  input  logic        err_inject,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned T_START = MIN_START_US  * CLKS_PER_US;
  localparam int unsigned T_RESP  = RESP_DELAY_US * CLKS_PER_US;
  localparam int unsigned T_ACK   = ACK_US        * CLKS_PER_US;
  localparam int unsigned T_LOW   = BIT_LOW_US    * CLKS_PER_US;
  localparam int unsigned T_B0    = BIT0_HIGH_US  * CLKS_PER_US;
  localparam int unsigned T_B1    = BIT1_HIGH_US  * CLKS_PER_US;

  localparam int unsigned T_M1  = (T_START > T_RESP) ? T_START : T_RESP;
  localparam int unsigned T_M2  = (T_M1 > T_ACK) ? T_M1 : T_ACK;
  localparam int unsigned T_M3  = (T_M2 > T_LOW) ? T_M2 : T_LOW;
  localparam int unsigned T_M4  = (T_M3 > T_B1) ? T_M3 : T_B1;
  localparam int unsigned T_MAX = (T_M4 > T_B0) ? T_M4 : T_B0;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t START_MIN = cnt_t'(T_START);
  localparam cnt_t RESP_END  = cnt_t'(T_RESP - 1);
  localparam cnt_t ACK_END   = cnt_t'(T_ACK - 1);
  localparam cnt_t LOW_END   = cnt_t'(T_LOW - 1);
  localparam cnt_t B0_END    = cnt_t'(T_B0 - 1);
  localparam cnt_t B1_END    = cnt_t'(T_B1 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RESP_DELAY,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t      state;
  cnt_t        cnt;
  logic        sync1;
  logic        line;
  logic        armed;
  logic [39:0] shreg;
  logic [5:0]  bit_idx;
  logic [7:0]  cks_now;
  logic        cur_bit;
  cnt_t        high_end;

  // Two-flop synchronizer for the pad input; resets to the idle (high) bus level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= dht_in;
      line  <= sync1;
    end
  end

  // Checksum of the live inputs, captured into the frame only at start acceptance.
  always_comb begin
    cks_now  = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
    cks_now  = cks_now ^ {8{err_inject}};
    cur_bit  = shreg[39];
    high_end = cur_bit ? B1_END : B0_END;
  end

  // Responder FSM with a single shared duration counter and registered bus enable.
  // A start is only recognised after the line has been seen high while idle,
  // which both ignores a bus held low out of reset and masks the synchronizer
  // still carrying our own end-of-frame low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      armed      <= 1'b0;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          dht_oe <= 1'b0;
          if (line) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            cnt   <= '0;
            state <= START_LOW;
          end
        end
        START_LOW: begin
          if (line) begin
            cnt <= '0;
            if (cnt >= START_MIN) begin
              shreg   <= {humidity, temperature, cks_now};
              bit_idx <= '0;
              busy    <= 1'b1;
              state   <= RESP_DELAY;
            end else begin
              state <= IDLE;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP_DELAY: begin
          if (cnt == RESP_END) begin
            cnt    <= '0;
            dht_oe <= 1'b1;
            state  <= ACK_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK_LOW: begin
          if (cnt == ACK_END) begin
            cnt    <= '0;
            dht_oe <= 1'b0;
            state  <= ACK_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK_HIGH: begin
          if (cnt == ACK_END) begin
            cnt    <= '0;
            dht_oe <= 1'b1;
            state  <= BIT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_LOW: begin
          if (cnt == LOW_END) begin
            cnt    <= '0;
            dht_oe <= 1'b0;
            state  <= BIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_HIGH: begin
          if (cnt == high_end) begin
            cnt     <= '0;
            dht_oe  <= 1'b1;
            shreg   <= {shreg[38:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
            state   <= (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        END_LOW: begin
          if (cnt == LOW_END) begin
            cnt        <= '0;
            dht_oe     <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          dht_oe <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
